// File: rtl/priv_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | priv_reg_bank : register bank with per-register privilege checks and
// |                 violation-counting lockout.  Rev 1.0
// +----------------------------------------------------------------------------
module priv_reg_bank #(
  parameter int                    NUM_REGS    = 8,
  parameter int                    DATA_W      = 32,
  parameter int                    ADDR_W      = $clog2(NUM_REGS) + 1,
  parameter logic [2*NUM_REGS-1:0] ACCESS_MAP  = '0,
  parameter int                    CNT_W       = 8,
  parameter int                    LOCK_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_priv,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [CNT_W-1:0]  viol_count,
  output logic              locked,
  input  logic              clr_viol
);

  localparam int                IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_REGS);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  THRESH   = CNT_W'(LOCK_THRESH);
  localparam logic [1:0]        ERR_OK     = 2'b00;
  localparam logic [1:0]        ERR_PRIV   = 2'b01;
  localparam logic [1:0]        ERR_DEC    = 2'b10;
  localparam logic [1:0]        ERR_LOCKED = 2'b11;

  typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t            state, state_next;
  logic              accept;
  logic [DATA_W-1:0] regs  [NUM_REGS];
  logic [1:0]        level [NUM_REGS];
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic [1:0]        eff_priv;
  logic [1:0]        chk_err;
  logic [DATA_W-1:0] rd_data;
  logic              counted;
  logic [CNT_W-1:0]  cnt_inc;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_level
    assign level[i] = ACCESS_MAP[2*i +: 2];
  end

  assign idx      = req_addr[IDX_W-1:0];
  assign in_range = (req_addr < ADDR_LIM);
  assign eff_priv = req_priv[1] ? 2'd2 : req_priv;

  always_comb begin
    chk_err = ERR_OK;
    if (!in_range)
      chk_err = ERR_DEC;
    else if (locked && (eff_priv < 2'd2))
      chk_err = ERR_LOCKED;
    else if (eff_priv < level[idx])
      chk_err = ERR_PRIV;
  end

  always_comb begin
    rd_data = '0;
    if (!req_write && (chk_err == ERR_OK))
      rd_data = regs[idx];
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~rst;
        if (req_valid && !rst)
          state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept  = req_valid & req_ready;
  assign counted = accept && ((chk_err == ERR_PRIV) || (chk_err == ERR_LOCKED));
  assign cnt_inc = (viol_count == CNT_MAX) ? viol_count : viol_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      state <= state_next;
      if (accept) begin
        rsp_rdata <= rd_data;
        rsp_err   <= chk_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (accept && req_write && (chk_err == ERR_OK)) begin
      regs[idx] <= req_wdata;
    end
  end

  // Clear beats a simultaneous violation; lock is judged on the post-increment count.
  always_ff @(posedge clk) begin
    if (rst || clr_viol) begin
      viol_count <= '0;
      locked     <= 1'b0;
    end else if (counted) begin
      viol_count <= cnt_inc;
      if (cnt_inc >= THRESH)
        locked <= 1'b1;
    end
  end

endmodule
`default_nettype wire
